lab4_sys_mem_arb: RTL and testbench

Round-robin arbiter that shares one 16B memory request/response port among `p_num_ports` cache refill ports. It sits between the per-core instruction caches and the shared instruction memory port in the multi-core system. Requests pass through combinationally. Each grant pushes the winning port index into a tag FIFO, and the FIFO head steers each memory response back to its originating cache. The memory side returns responses in request order.

---
 rtl/lab4_sys_mem_arb_pkg.sv | 29 ++
 rtl/lab4_sys_mem_arb_if.sv | 52 +++++
 rtl/lab4_sys_mem_arb_rr.sv | 54 +++++
 rtl/lab4_sys_mem_arb.sv | 119 +++++++++++
 tb/tb_lab4_sys_mem_arb.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lab4_sys_mem_arb_pkg.sv
// lab4_sys_MemArbPkg: shared types and limits for the memory arbiter.
//   MAX_PORTS / MAX_DEPTH : upper bounds for requester count and tag FIFO depth
//   port_idx_t            : index wide enough for any legal port number
//   mem_req_16B_t         : 16B memory request message (opaque passed through)
//   mem_resp_16B_t        : 16B memory response message
package lab4_sys_MemArbPkg;

    localparam int MAX_PORTS = 8;
    localparam int MAX_DEPTH = 16;

    typedef logic [$clog2(MAX_PORTS)-1:0] port_idx_t;

    typedef struct packed {
        logic [2:0]   typ;
        logic [7:0]   opaque;
        logic [31:0]  addr;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_req_16B_t;

    typedef struct packed {
        logic [2:0]   typ;
        logic [7:0]   opaque;
        logic [1:0]   test;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_resp_16B_t;

endpackage

// File: rtl/lab4_sys_mem_arb_if.sv
// lab4_sys_mem_arb_if: cache-side and memory-side val/rdy streams of the
// memory arbiter.
//   cache2net_reqstream_*  : per-port requests from the caches
//   cache2net_respstream_* : per-port responses back to the caches
//   net2mem_reqstream_*    : single request stream toward memory
//   net2mem_respstream_*   : single response stream from memory
//   modport slave  : arbiter view
//   modport master : environment view (caches + memory)
interface lab4_sys_mem_arb_if #(
    parameter int p_num_ports = 4
);
    import lab4_sys_MemArbPkg::*;

    mem_req_16B_t               cache2net_reqstream_msg [p_num_ports];
    logic [p_num_ports-1:0]     cache2net_reqstream_val;
    logic [p_num_ports-1:0]     cache2net_reqstream_rdy;

    mem_resp_16B_t              cache2net_respstream_msg [p_num_ports];
    logic [p_num_ports-1:0]     cache2net_respstream_val;
    logic [p_num_ports-1:0]     cache2net_respstream_rdy;

    mem_req_16B_t               net2mem_reqstream_msg;
    logic                       net2mem_reqstream_val;
    logic                       net2mem_reqstream_rdy;

    mem_resp_16B_t              net2mem_respstream_msg;
    logic                       net2mem_respstream_val;
    logic                       net2mem_respstream_rdy;

    modport slave (
        input  cache2net_reqstream_msg, cache2net_reqstream_val,
        output cache2net_reqstream_rdy,
        output cache2net_respstream_msg, cache2net_respstream_val,
        input  cache2net_respstream_rdy,
        output net2mem_reqstream_msg, net2mem_reqstream_val,
        input  net2mem_reqstream_rdy,
        input  net2mem_respstream_msg, net2mem_respstream_val,
        output net2mem_respstream_rdy
    );

    modport master (
        output cache2net_reqstream_msg, cache2net_reqstream_val,
        input  cache2net_reqstream_rdy,
        input  cache2net_respstream_msg, cache2net_respstream_val,
        output cache2net_respstream_rdy,
        input  net2mem_reqstream_msg, net2mem_reqstream_val,
        output net2mem_reqstream_rdy,
        output net2mem_respstream_msg, net2mem_respstream_val,
        input  net2mem_respstream_rdy
    );

endinterface

// File: rtl/lab4_sys_mem_arb_rr.sv
// lab4_sys_RoundRobinArb: round-robin selection among requesting ports.
//   clk, reset : clock, asynchronous active-low reset
//   req        : per-port request valid (eligible mask)
//   en         : advance the priority pointer past the current winner
//   any        : at least one port is eligible
//   winner     : index of the first eligible port at or after prio
//   grant      : one-hot of winner, all zero when nothing is eligible
module lab4_sys_RoundRobinArb
    import lab4_sys_MemArbPkg::*;
#(
    parameter int p_num_ports = 4
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [p_num_ports-1:0] req,
    input  logic                   en,
    output logic                   any,
    output port_idx_t              winner,
    output logic [p_num_ports-1:0] grant
);

    port_idx_t              prio;
    logic [p_num_ports-1:0] eligible;
    logic [p_num_ports-1:0] rot;

    assign eligible = req;

    // Rotate the mask so bit 0 is the port at prio; the lowest set bit of
    // the rotated mask is then the search distance to the winner.
    always_comb begin
        int w;
        rot = p_num_ports'({eligible, eligible} >> prio);
        any = |rot;
        w   = int'(prio);
        for (int i = p_num_ports - 1; i >= 0; i--) begin
            if (rot[i]) w = int'(prio) + i;
        end
        if (w >= p_num_ports) w = w - p_num_ports;
        winner = port_idx_t'(w);
        grant  = '0;
        for (int k = 0; k < p_num_ports; k++) begin
            grant[k] = any && (k == w);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio <= '0;
        end else if (en) begin
            prio <= (winner == port_idx_t'(p_num_ports - 1)) ? '0 : winner + port_idx_t'(1);
        end
    end

endmodule

// File: rtl/lab4_sys_mem_arb.sv
// lab4_sys_mem_arb: round-robin arbiter sharing one 16B memory port among
// p_num_ports cache refill ports. Requests and responses pass through
// combinationally; a tag FIFO of granted port indices steers in-order
// memory responses back to their caches.
//   clk, reset  : clock, asynchronous active-low reset
//   bus         : lab4_sys_mem_arb_if.slave (all request/response streams)
//   grant_count : per-port grant totals, only when LAB4_SYS_MEM_ARB_STATS_EN
//                 is defined
module lab4_sys_mem_arb
    import lab4_sys_MemArbPkg::*;
#(
    parameter int p_num_ports       = 4,
    parameter int p_max_outstanding = 4
)(
    input  logic               clk,
    input  logic               reset,
    lab4_sys_mem_arb_if.slave  bus
`ifdef LAB4_SYS_MEM_ARB_STATS_EN
    ,
    output logic [31:0]        grant_count [p_num_ports]
`endif
);

    localparam int PW = $clog2(p_max_outstanding);
    localparam int CW = $clog2(p_max_outstanding + 1);

    logic                   any;
    port_idx_t              winner;
    logic [p_num_ports-1:0] grant;

    port_idx_t              tag_q [p_max_outstanding];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    logic                   full;
    logic                   empty;
    port_idx_t              head;
    logic [p_num_ports-1:0] head_onehot;
    logic                   req_fire;
    logic                   resp_fire;

    assign full  = (count == CW'(p_max_outstanding));
    assign empty = (count == '0);
    assign head  = tag_q[rd_ptr];

    lab4_sys_RoundRobinArb #(
        .p_num_ports (p_num_ports)
    ) u_rr (
        .clk    (clk),
        .reset  (reset),
        .req    (bus.cache2net_reqstream_val),
        .en     (req_fire),
        .any    (any),
        .winner (winner),
        .grant  (grant)
    );

    // Request path. Outputs are forced to zero while reset is held.
    always_comb begin
        bus.net2mem_reqstream_val   = reset & any & ~full;
        bus.cache2net_reqstream_rdy = {p_num_ports{reset & bus.net2mem_reqstream_rdy & ~full}} & grant;
        bus.net2mem_reqstream_msg   = '0;
        for (int k = 0; k < p_num_ports; k++) begin
            if (reset && grant[k]) bus.net2mem_reqstream_msg = bus.cache2net_reqstream_msg[k];
        end
    end

    assign req_fire = bus.net2mem_reqstream_val & bus.net2mem_reqstream_rdy;

    // Response path: the FIFO head picks the destination; an empty FIFO
    // leaves any stray memory response waiting.
    always_comb begin
        for (int k = 0; k < p_num_ports; k++) begin
            head_onehot[k] = (head == port_idx_t'(k));
        end
        bus.net2mem_respstream_rdy   = reset & ~empty & |(head_onehot & bus.cache2net_respstream_rdy);
        bus.cache2net_respstream_val = {p_num_ports{reset & ~empty & bus.net2mem_respstream_val}} & head_onehot;
        for (int k = 0; k < p_num_ports; k++) begin
            bus.cache2net_respstream_msg[k] = reset ? bus.net2mem_respstream_msg : '0;
        end
    end

    assign resp_fire = bus.net2mem_respstream_rdy & bus.net2mem_respstream_val;

    // Tag FIFO control. Pushes are already blocked when full, so a
    // simultaneous push and pop never exceeds the depth.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (req_fire)  wr_ptr <= wr_ptr + PW'(1);
            if (resp_fire) rd_ptr <= rd_ptr + PW'(1);
            case ({req_fire, resp_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) tag_q[wr_ptr] <= winner;
    end

`ifdef LAB4_SYS_MEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < p_num_ports; k++) grant_count[k] <= '0;
        end else if (req_fire) begin
            for (int k = 0; k < p_num_ports; k++) begin
                if (grant[k]) grant_count[k] <= grant_count[k] + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lab4_sys_mem_arb.sv
module tb_lab4_sys_mem_arb;
    import lab4_sys_MemArbPkg::*;

    localparam int N = 4;
    localparam int D = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    lab4_sys_mem_arb_if #(.p_num_ports(N)) bus ();

`ifdef LAB4_SYS_MEM_ARB_STATS_EN
    logic [31:0] grant_count [N];
`endif

    lab4_sys_mem_arb #(
        .p_num_ports       (N),
        .p_max_outstanding (D)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef LAB4_SYS_MEM_ARB_STATS_EN
        ,
        .grant_count (grant_count)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic [N-1:0] val, input logic mrdy, input logic rval, input logic [N-1:0] crdy);
        bus.cache2net_reqstream_val  = val;
        bus.net2mem_reqstream_rdy    = mrdy;
        bus.net2mem_respstream_val   = rval;
        bus.cache2net_respstream_rdy = crdy;
    endtask

    task automatic set_fixed_msgs();
        mem_req_16B_t m;
        for (int k = 0; k < N; k++) begin
            m        = '0;
            m.opaque = 8'(8'h10 + k);
            m.addr   = 32'h2000 + 32'(k * 16);
            m.data   = 128'(k + 1);
            bus.cache2net_reqstream_msg[k] = m;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        drive('0, 1'b0, 1'b0, '0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0] val;
        logic         mrdy;
        logic         rval;
        logic [N-1:0] crdy;
        logic         exp_mval;
        logic [N-1:0] exp_rdy;
        logic [7:0]   exp_opq;
        logic         exp_mrrdy;
        logic [N-1:0] exp_cval;
    } vec_t;

    vec_t tbl [16];

    // Reference model state
    int          m_prio;
    int          m_q [$];
    int unsigned m_grants [N];

    initial begin
        mem_req_16B_t  rm;
        mem_resp_16B_t pm;
        mem_req_16B_t  req_msgs [N];

        tbl[0]  = '{4'b1111, 1'b1, 1'b0, 4'b1111, 1'b1, 4'b0001, 8'h10, 1'b0, 4'b0000};
        tbl[1]  = '{4'b1111, 1'b1, 1'b0, 4'b1111, 1'b1, 4'b0010, 8'h11, 1'b1, 4'b0000};
        tbl[2]  = '{4'b1111, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0100, 8'h12, 1'b1, 4'b0001};
        tbl[3]  = '{4'b1111, 1'b1, 1'b1, 4'b1101, 1'b1, 4'b1000, 8'h13, 1'b0, 4'b0010};
        tbl[4]  = '{4'b1010, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 8'h11, 1'b1, 4'b0000};
        tbl[5]  = '{4'b1010, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 8'h11, 1'b1, 4'b0000};
        tbl[6]  = '{4'b1010, 1'b1, 1'b0, 4'b1111, 1'b1, 4'b0010, 8'h11, 1'b1, 4'b0000};
        tbl[7]  = '{4'b1010, 1'b1, 1'b0, 4'b1111, 1'b0, 4'b0000, 8'h13, 1'b1, 4'b0000};
        tbl[8]  = '{4'b1010, 1'b1, 1'b1, 4'b1111, 1'b0, 4'b0000, 8'h13, 1'b1, 4'b0010};
        tbl[9]  = '{4'b1010, 1'b1, 1'b0, 4'b1111, 1'b1, 4'b1000, 8'h13, 1'b1, 4'b0000};
        tbl[10] = '{4'b0000, 1'b1, 1'b1, 4'b1111, 1'b0, 4'b0000, 8'h00, 1'b1, 4'b0100};
        tbl[11] = '{4'b0000, 1'b1, 1'b1, 4'b0111, 1'b0, 4'b0000, 8'h00, 1'b0, 4'b1000};
        tbl[12] = '{4'b0000, 1'b1, 1'b1, 4'b1111, 1'b0, 4'b0000, 8'h00, 1'b1, 4'b1000};
        tbl[13] = '{4'b0000, 1'b1, 1'b1, 4'b1111, 1'b0, 4'b0000, 8'h00, 1'b1, 4'b0010};
        tbl[14] = '{4'b0000, 1'b1, 1'b1, 4'b1111, 1'b0, 4'b0000, 8'h00, 1'b1, 4'b1000};
        tbl[15] = '{4'b0000, 1'b1, 1'b1, 4'b1111, 1'b0, 4'b0000, 8'h00, 1'b0, 4'b0000};

        // Reset held with active inputs: every output must be quiet
        set_fixed_msgs();
        pm = '0; pm.opaque = 8'h77; pm.data = 128'hABCD;
        bus.net2mem_respstream_msg = pm;
        drive(4'b1111, 1'b1, 1'b1, 4'b1111);
        #1;
        check("rst_mval",  192'(bus.net2mem_reqstream_val), 192'(0));
        check("rst_rdy",   192'(bus.cache2net_reqstream_rdy), 192'(0));
        check("rst_mrrdy", 192'(bus.net2mem_respstream_rdy), 192'(0));
        check("rst_cval",  192'(bus.cache2net_respstream_val), 192'(0));
        check("rst_msg",   192'(bus.net2mem_reqstream_msg), 192'(0));
        check("rst_rmsg",  192'(bus.cache2net_respstream_msg[2]), 192'(0));
        check("rst_prio",  192'(dut.u_rr.prio), 192'(0));
        check("rst_count", 192'(dut.count), 192'(0));
        @(negedge clk);
        reset = 1'b1;

        // Single requester: port 2 reads 0x1000, response two cycles later
        rm = '0; rm.typ = 3'd0; rm.opaque = 8'h5A; rm.addr = 32'h1000; rm.len = 4'd0;
        bus.cache2net_reqstream_msg[2] = rm;
        drive(4'b0100, 1'b1, 1'b0, 4'b1111);
        #1;
        check("single_mval", 192'(bus.net2mem_reqstream_val), 192'(1));
        check("single_msg",  192'(bus.net2mem_reqstream_msg), 192'(rm));
        check("single_rdy",  192'(bus.cache2net_reqstream_rdy), 192'(4'b0100));
        @(negedge clk);
        drive(4'b0000, 1'b1, 1'b0, 4'b1111);
        #1;
        check("single_wait_cval", 192'(bus.cache2net_respstream_val), 192'(0));
        @(negedge clk);
        pm = '0; pm.opaque = 8'h5A; pm.data = 128'hFEED;
        bus.net2mem_respstream_msg = pm;
        drive(4'b0000, 1'b1, 1'b1, 4'b1111);
        #1;
        check("single_cval",  192'(bus.cache2net_respstream_val), 192'(4'b0100));
        check("single_mrrdy", 192'(bus.net2mem_respstream_rdy), 192'(1));
        check("single_rmsg",  192'(bus.cache2net_respstream_msg[2]), 192'(pm));
        @(negedge clk);
        drive(4'b0000, 1'b1, 1'b0, 4'b1111);
        #1;
        check("single_empty", 192'(dut.count), 192'(0));
        check("single_quiet", 192'(bus.cache2net_respstream_val), 192'(0));

        // Table: rotation, stall hold, FIFO full, backpressure, stray response
        do_reset();
        set_fixed_msgs();
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].val, tbl[i].mrdy, tbl[i].rval, tbl[i].crdy);
            #1;
            check($sformatf("t%0d_mval", i),  192'(bus.net2mem_reqstream_val),    192'(tbl[i].exp_mval));
            check($sformatf("t%0d_rdy", i),   192'(bus.cache2net_reqstream_rdy),  192'(tbl[i].exp_rdy));
            if (tbl[i].val != '0)
                check($sformatf("t%0d_opq", i), 192'(bus.net2mem_reqstream_msg.opaque), 192'(tbl[i].exp_opq));
            check($sformatf("t%0d_mrrdy", i), 192'(bus.net2mem_respstream_rdy),   192'(tbl[i].exp_mrrdy));
            check($sformatf("t%0d_cval", i),  192'(bus.cache2net_respstream_val), 192'(tbl[i].exp_cval));
            if (i == 5) check("stall_prio", 192'(dut.u_rr.prio), 192'(0));
            @(negedge clk);
        end

        // Stats (when built in) and asynchronous reset mid-burst
        do_reset();
        drive(4'b0010, 1'b1, 1'b0, 4'b1111);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
`ifdef LAB4_SYS_MEM_ARB_STATS_EN
        #1;
        check("stats_gc1", 192'(grant_count[1]), 192'(3));
        check("stats_gc0", 192'(grant_count[0]), 192'(0));
`endif
        check("burst_count", 192'(dut.count), 192'(3));
        drive(4'b1111, 1'b1, 1'b0, 4'b1111);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_prio",  192'(dut.u_rr.prio), 192'(0));
        check("midrst_count", 192'(dut.count), 192'(0));
        check("midrst_mval",  192'(bus.net2mem_reqstream_val), 192'(0));
        check("midrst_rdy",   192'(bus.cache2net_reqstream_rdy), 192'(0));
`ifdef LAB4_SYS_MEM_ARB_STATS_EN
        check("midrst_gc1", 192'(grant_count[1]), 192'(0));
`endif
        @(negedge clk);
        reset = 1'b1;

        // Randomized traffic against the reference model
        do_reset();
        m_prio = 0;
        m_q.delete();
        for (int k = 0; k < N; k++) m_grants[k] = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            logic [N-1:0] val, crdy, exp_rdy, exp_cval;
            logic         mrdy, rval, exp_mval, exp_mrrdy;
            int           w, h, pick;
            for (int k = 0; k < N; k++) begin
                rm        = '0;
                rm.typ    = 3'($urandom);
                rm.opaque = 8'($urandom);
                rm.addr   = $urandom;
                rm.len    = 4'($urandom);
                rm.data   = {$urandom, $urandom, $urandom, $urandom};
                req_msgs[k] = rm;
                bus.cache2net_reqstream_msg[k] = rm;
            end
            pm        = '0;
            pm.opaque = 8'($urandom);
            pm.test   = 2'($urandom);
            pm.data   = {$urandom, $urandom, $urandom, $urandom};
            bus.net2mem_respstream_msg = pm;
            val  = N'($urandom);
            mrdy = ($urandom_range(0, 3) != 0);
            rval = ($urandom_range(0, 1) != 0);
            crdy = N'($urandom);
            drive(val, mrdy, rval, crdy);

            w = -1;
            for (int i = 0; i < N; i++) begin
                if (w < 0 && val[(m_prio + i) % N]) w = (m_prio + i) % N;
            end
            exp_mval = (w >= 0) && (m_q.size() < D);
            exp_rdy  = (exp_mval && mrdy) ? N'(1 << w) : '0;
            if (m_q.size() > 0) begin
                h         = m_q[0];
                exp_mrrdy = crdy[h];
                exp_cval  = rval ? N'(1 << h) : '0;
            end else begin
                exp_mrrdy = 1'b0;
                exp_cval  = '0;
            end

            #1;
            check("rnd_mval",  192'(bus.net2mem_reqstream_val),    192'(exp_mval));
            check("rnd_rdy",   192'(bus.cache2net_reqstream_rdy),  192'(exp_rdy));
            if (w >= 0) check("rnd_msg", 192'(bus.net2mem_reqstream_msg), 192'(req_msgs[w]));
            check("rnd_mrrdy", 192'(bus.net2mem_respstream_rdy),   192'(exp_mrrdy));
            check("rnd_cval",  192'(bus.cache2net_respstream_val), 192'(exp_cval));
            pick = $urandom_range(0, N - 1);
            check("rnd_rmsg",  192'(bus.cache2net_respstream_msg[pick]), 192'(pm));

            if (exp_mrrdy && rval) void'(m_q.pop_front());
            if (exp_mval && mrdy) begin
                m_q.push_back(w);
                m_prio = (w + 1) % N;
                m_grants[w]++;
            end
            @(negedge clk);
        end
        check("rnd_count", 192'(dut.count), 192'(m_q.size()));
`ifdef LAB4_SYS_MEM_ARB_STATS_EN
        for (int k = 0; k < N; k++)
            check($sformatf("rnd_gc%0d", k), 192'(grant_count[k]), 192'(m_grants[k]));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
